rv_pipe_ctrl: RTL and testbench
===============================

# rv_pipe_ctrl

Pipeline sequencer for the FlexRV32 core. It watches the decode and ALU1 stages and the data bus, and produces per-stage stall and flush controls plus the fetch redirect. It handles load-use bubbles, jump/branch redirects, memory wait stalls and trap entry. It sits beside the stage registers and drives the `i_flush` of ALU1 and the equivalent controls of fetch and decode.

## Interface
Parameters:
- IADDR_SPACE_BITS, 32, instruction address width

Ports:
- i_clk  in  1  core clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_dec_valid  in  1  decode stage holds a valid instruction
- i_dec_rs1  in  5  decode source register 1
- i_dec_rs2  in  5  decode source register 2
- i_alu_rd  in  5  ALU1 destination register
- i_alu_load  in  1  ALU1 instruction is a load (res_src memory)
- i_alu_reg_write  in  1  ALU1 writes rd
- i_alu_jump  in  1  ALU1 holds jal/jalr/mret (o_inst_jal_jalr)
- i_alu_branch  in  1  ALU1 holds a conditional branch
- i_alu_cond  in  1  branch condition true
- i_alu_branch_pred  in  1  fetch predicted taken
- i_alu_pc_target  in  IADDR_SPACE_BITS  computed target
- i_alu_pc_next  in  IADDR_SPACE_BITS  fall-through PC
- i_alu_to_trap  in  1  ALU1 instruction raises a trap
- i_trap_vector  in  IADDR_SPACE_BITS  trap handler address
- i_mem_busy  in  1  data bus not ready
- o_stall_fetch / o_stall_decode / o_stall_alu  out  1 each  hold stage register
- o_flush_decode / o_flush_alu  out  1 each  clear stage register at next edge
- o_pc_redirect  out  1  fetch loads o_pc_new at next edge
- o_pc_new  out  IADDR_SPACE_BITS  redirect address
- o_trap_take  out  1  one-cycle pulse on trap entry

## Operation
- States: RUN, FLUSH, TRAP_DRAIN, TRAP_GO.
- taken = i_alu_jump | (i_alu_branch & i_alu_cond).
- Load-use hazard = i_dec_valid & i_alu_load & i_alu_reg_write & i_alu_rd≠0 & (i_alu_rd==i_dec_rs1 | i_alu_rd==i_dec_rs2).
- Priority in RUN, highest first: trap, mem busy, redirect, load-use.
  - Trap: set state TRAP_DRAIN.
  - Mem busy: stall all three stages; no redirect.
  - Redirect: o_pc_redirect=1, o_flush_decode=1, o_flush_alu=1; set state FLUSH.
  - Load-use: stall fetch and decode, o_flush_alu=1 (one bubble).
- FLUSH: o_flush_decode=1 for one cycle to kill the in-flight fetch; then RUN. If i_mem_busy, stall fetch and stay in FLUSH.
- TRAP_DRAIN: stall fetch/decode, flush ALU every cycle; when !i_mem_busy, go to TRAP_GO.
- TRAP_GO: o_pc_redirect=1, o_pc_new=i_trap_vector, o_trap_take=1, flush decode and ALU; then FLUSH.
- A redirect coinciding with load-use: redirect wins, since the hazard is on the wrong path.
- Mem busy during redirect: redirect is suppressed. The ALU instruction is held, so the redirect re-asserts once i_mem_busy drops.

## Timing
- State register only; all outputs are combinational from the state and registered stage inputs, with zero latency.
- Reset (async assert, sync release): state=RUN. While i_reset_n=0, all outputs are forced to 0 and o_pc_new to 0.
- A redirect costs 2 bubble cycles: the RUN cycle plus the FLUSH cycle.
- Trap entry costs 2 cycles minimum (TRAP_DRAIN, TRAP_GO), plus one TRAP_DRAIN cycle per i_mem_busy cycle, plus FLUSH.
- Reset asserted mid-trap or mid-flush returns to RUN with no o_trap_take pulse.

## Configuration
- RV_BRANCH_PRED_EN defined: redirect = taken ≠ i_alu_branch_pred; o_pc_new = taken ? i_alu_pc_target : i_alu_pc_next.
  - jal/jalr/mret still use the same rule.
- Undefined: static not-taken; redirect = taken; o_pc_new = i_alu_pc_target; i_alu_branch_pred is ignored.

## Structure
- Add `pctrl_state_t` (2-bit enum) to the shared structs package.
- Sub-module `rv_hazard_detect`: combinational load-use compare, instantiated once.

## Test plan
- Load x5 in ALU1, decode `add x6,x5,x1`: exactly one cycle with stall_fetch=stall_decode=flush_alu=1, then normal flow. Repeat with rd=x0: no stall.
- Undefined macro, taken branch with target 0x100: o_pc_redirect=1 and o_pc_new=0x100 for one cycle, then FLUSH with flush_decode=1, then RUN.
- RV_BRANCH_PRED_EN, branch predicted taken but not taken, pc_next=0x24: redirect to 0x24. Predicted taken and taken: no redirect.
- i_alu_to_trap with i_mem_busy high for 3 cycles, trap_vector 0x80: 4 TRAP_DRAIN cycles, then TRAP_GO with o_trap_take pulse and redirect to 0x80.
- Taken jump with i_mem_busy=1 for 2 cycles: all stages stalled and no redirect; redirect fires in the cycle busy drops.
- Reset asserted during TRAP_DRAIN: outputs immediately 0; after release, state is RUN and no trap pulse is seen.

Source files
------------

// File: rtl/rv_pipe_ctrl_pkg.sv
// rtl/rv_pipe_ctrl_pkg.sv - shared types for the FlexRV32 pipeline sequencer
//
// Purpose: holds the sequencer state encoding used by rv_pipe_ctrl.
// Ports: none (package).
package rv_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    TRAP_DRAIN = 2'd2,
    TRAP_GO    = 2'd3
  } pctrl_state_t;

  localparam int unsigned REG_ADDR_BITS = 5;

endpackage

// File: rtl/rv_hazard_detect.sv
// rtl/rv_hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags when the instruction in decode reads the register that a
// load currently in ALU1 is about to write, so one bubble must be inserted.
// Ports:
//   i_dec_valid      decode stage holds a valid instruction
//   i_dec_rs1/rs2    decode source registers
//   i_alu_rd         ALU1 destination register
//   i_alu_load       ALU1 instruction is a load
//   i_alu_reg_write  ALU1 writes rd
//   o_load_use       hazard present
module rv_hazard_detect
  import rv_pipe_ctrl_pkg::*;
(
  input  logic                     i_dec_valid,
  input  logic [REG_ADDR_BITS-1:0] i_dec_rs1,
  input  logic [REG_ADDR_BITS-1:0] i_dec_rs2,
  input  logic [REG_ADDR_BITS-1:0] i_alu_rd,
  input  logic                     i_alu_load,
  input  logic                     i_alu_reg_write,
  output logic                     o_load_use
);

  logic rd_nonzero;
  logic rd_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_nonzero = (i_alu_rd != '0);
  assign rd_match   = (i_alu_rd == i_dec_rs1) || (i_alu_rd == i_dec_rs2);
  assign o_load_use = i_dec_valid && i_alu_load && i_alu_reg_write && rd_nonzero && rd_match;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// rtl/rv_pipe_ctrl.sv - FlexRV32 pipeline sequencer (stall/flush/redirect/trap)
//
// Purpose: watches decode, ALU1 and the data bus and drives per-stage stall
// and flush controls, the fetch redirect and the trap-entry pulse.
// Optional feature macro: RV_BRANCH_PRED_EN (redirect on misprediction
// instead of static not-taken).
// Ports:
//   i_clk, i_reset_n                      clock, async active-low reset
//   i_dec_valid, i_dec_rs1, i_dec_rs2     decode stage operands
//   i_alu_rd, i_alu_load, i_alu_reg_write ALU1 destination info
//   i_alu_jump, i_alu_branch, i_alu_cond  ALU1 control-flow info
//   i_alu_branch_pred                     fetch predicted taken
//   i_alu_pc_target, i_alu_pc_next        taken / fall-through PC
//   i_alu_to_trap, i_trap_vector          trap request and handler address
//   i_mem_busy                            data bus not ready
//   o_stall_fetch/decode/alu              hold stage registers
//   o_flush_decode/alu                    clear stage registers
//   o_pc_redirect, o_pc_new               fetch redirect
//   o_trap_take                           one-cycle trap-entry pulse
module rv_pipe_ctrl
  import rv_pipe_ctrl_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_dec_valid,
  input  logic [4:0]                  i_dec_rs1,
  input  logic [4:0]                  i_dec_rs2,
  input  logic [4:0]                  i_alu_rd,
  input  logic                        i_alu_load,
  input  logic                        i_alu_reg_write,
  input  logic                        i_alu_jump,
  input  logic                        i_alu_branch,
  input  logic                        i_alu_cond,
  input  logic                        i_alu_branch_pred,
  input  logic [IADDR_SPACE_BITS-1:0] i_alu_pc_target,
  input  logic [IADDR_SPACE_BITS-1:0] i_alu_pc_next,
  input  logic                        i_alu_to_trap,
  input  logic [IADDR_SPACE_BITS-1:0] i_trap_vector,
  input  logic                        i_mem_busy,
  output logic                        o_stall_fetch,
  output logic                        o_stall_decode,
  output logic                        o_stall_alu,
  output logic                        o_flush_decode,
  output logic                        o_flush_alu,
  output logic                        o_pc_redirect,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_new,
  output logic                        o_trap_take
);

  pctrl_state_t state, state_next;

  logic                        load_use;
  logic                        taken;
  logic                        redirect_req;
  logic [IADDR_SPACE_BITS-1:0] redirect_addr;

  rv_hazard_detect u_hazard (
    .i_dec_valid    (i_dec_valid),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .i_alu_rd       (i_alu_rd),
    .i_alu_load     (i_alu_load),
    .i_alu_reg_write(i_alu_reg_write),
    .o_load_use     (load_use)
  );

  assign taken = i_alu_jump | (i_alu_branch & i_alu_cond);

`ifdef RV_BRANCH_PRED_EN
  // Fetch already followed the prediction; only a wrong guess needs fixing,
  // and the fix is whichever path the prediction did not take.
  assign redirect_req  = (taken != i_alu_branch_pred);
  assign redirect_addr = taken ? i_alu_pc_target : i_alu_pc_next;
`else
  // Static not-taken: fetch always runs sequentially, so every taken
  // transfer is a redirect to the computed target.
  assign redirect_req  = taken;
  assign redirect_addr = i_alu_pc_target;

  logic unused_cfg;
  assign unused_cfg = ^{i_alu_branch_pred, i_alu_pc_next};
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    o_stall_fetch  = 1'b0;
    o_stall_decode = 1'b0;
    o_stall_alu    = 1'b0;
    o_flush_decode = 1'b0;
    o_flush_alu    = 1'b0;
    o_pc_redirect  = 1'b0;
    o_pc_new       = redirect_addr;
    o_trap_take    = 1'b0;

    case (state)
      RUN: begin
        if (i_alu_to_trap) begin
          state_next = TRAP_DRAIN;
        end else if (i_mem_busy) begin
          // The ALU instruction is held here, so a pending redirect is
          // simply re-evaluated once the bus frees up.
          o_stall_fetch  = 1'b1;
          o_stall_decode = 1'b1;
          o_stall_alu    = 1'b1;
        end else if (redirect_req) begin
          // Redirect outranks load-use: the dependent instruction is on
          // the wrong path and is flushed anyway.
          o_pc_redirect  = 1'b1;
          o_flush_decode = 1'b1;
          o_flush_alu    = 1'b1;
          state_next     = FLUSH;
        end else if (load_use) begin
          o_stall_fetch  = 1'b1;
          o_stall_decode = 1'b1;
          o_flush_alu    = 1'b1;
        end
      end
      FLUSH: begin
        // Kills the instruction fetched from the old path while the
        // redirect was being taken.
        o_flush_decode = 1'b1;
        if (i_mem_busy) begin
          o_stall_fetch = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      TRAP_DRAIN: begin
        o_stall_fetch  = 1'b1;
        o_stall_decode = 1'b1;
        o_flush_alu    = 1'b1;
        if (!i_mem_busy) begin
          state_next = TRAP_GO;
        end
      end
      TRAP_GO: begin
        o_pc_redirect  = 1'b1;
        o_pc_new       = i_trap_vector;
        o_trap_take    = 1'b1;
        o_flush_decode = 1'b1;
        o_flush_alu    = 1'b1;
        state_next     = FLUSH;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    // Outputs are quiet for the whole reset window, not just after an edge.
    if (!i_reset_n) begin
      o_stall_fetch  = 1'b0;
      o_stall_decode = 1'b0;
      o_stall_alu    = 1'b0;
      o_flush_decode = 1'b0;
      o_flush_alu    = 1'b0;
      o_pc_redirect  = 1'b0;
      o_pc_new       = '0;
      o_trap_take    = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb/tb_rv_pipe_ctrl.sv - directed self-checking bench for rv_pipe_ctrl
module tb_rv_pipe_ctrl;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_dec_valid;
  logic [4:0]  i_dec_rs1;
  logic [4:0]  i_dec_rs2;
  logic [4:0]  i_alu_rd;
  logic        i_alu_load;
  logic        i_alu_reg_write;
  logic        i_alu_jump;
  logic        i_alu_branch;
  logic        i_alu_cond;
  logic        i_alu_branch_pred;
  logic [31:0] i_alu_pc_target;
  logic [31:0] i_alu_pc_next;
  logic        i_alu_to_trap;
  logic [31:0] i_trap_vector;
  logic        i_mem_busy;
  logic        o_stall_fetch;
  logic        o_stall_decode;
  logic        o_stall_alu;
  logic        o_flush_decode;
  logic        o_flush_alu;
  logic        o_pc_redirect;
  logic [31:0] o_pc_new;
  logic        o_trap_take;

  // {stall_fetch, stall_decode, stall_alu, flush_decode, flush_alu, redirect, trap_take}
  logic [6:0] ctl;
  assign ctl = {o_stall_fetch, o_stall_decode, o_stall_alu, o_flush_decode,
                o_flush_alu, o_pc_redirect, o_trap_take};

  localparam logic [6:0] C_IDLE     = 7'b0000000;
  localparam logic [6:0] C_LOADUSE  = 7'b1100100;
  localparam logic [6:0] C_REDIR    = 7'b0001110;
  localparam logic [6:0] C_FLUSH    = 7'b0001000;
  localparam logic [6:0] C_FLUSH_BZ = 7'b1001000;
  localparam logic [6:0] C_DRAIN    = 7'b1100100;
  localparam logic [6:0] C_TRAPGO   = 7'b0001111;
  localparam logic [6:0] C_MEMBUSY  = 7'b1110000;

  int checks = 0;
  int errors = 0;

  rv_pipe_ctrl #(.IADDR_SPACE_BITS(32)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_dec_valid      (i_dec_valid),
    .i_dec_rs1        (i_dec_rs1),
    .i_dec_rs2        (i_dec_rs2),
    .i_alu_rd         (i_alu_rd),
    .i_alu_load       (i_alu_load),
    .i_alu_reg_write  (i_alu_reg_write),
    .i_alu_jump       (i_alu_jump),
    .i_alu_branch     (i_alu_branch),
    .i_alu_cond       (i_alu_cond),
    .i_alu_branch_pred(i_alu_branch_pred),
    .i_alu_pc_target  (i_alu_pc_target),
    .i_alu_pc_next    (i_alu_pc_next),
    .i_alu_to_trap    (i_alu_to_trap),
    .i_trap_vector    (i_trap_vector),
    .i_mem_busy       (i_mem_busy),
    .o_stall_fetch    (o_stall_fetch),
    .o_stall_decode   (o_stall_decode),
    .o_stall_alu      (o_stall_alu),
    .o_flush_decode   (o_flush_decode),
    .o_flush_alu      (o_flush_alu),
    .o_pc_redirect    (o_pc_redirect),
    .o_pc_new         (o_pc_new),
    .o_trap_take      (o_trap_take)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_dec_valid       = 1'b0;
    i_dec_rs1         = 5'd0;
    i_dec_rs2         = 5'd0;
    i_alu_rd          = 5'd0;
    i_alu_load        = 1'b0;
    i_alu_reg_write   = 1'b0;
    i_alu_jump        = 1'b0;
    i_alu_branch      = 1'b0;
    i_alu_cond        = 1'b0;
    i_alu_branch_pred = 1'b0;
    i_alu_pc_target   = 32'h0;
    i_alu_pc_next     = 32'h0;
    i_alu_to_trap     = 1'b0;
    i_trap_vector     = 32'h0;
    i_mem_busy        = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    idle_inputs();
    i_alu_jump      = 1'b1;
    i_alu_pc_target = 32'h1234;
    i_trap_vector   = 32'h80;
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE);
    end
    checks++;
    if (o_pc_new !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc_new got %h want %h", o_pc_new, 32'h0);
    end
    repeat (2) @(posedge i_clk);
    #3;
    i_reset_n = 1'b1;
    idle_inputs();
    tick();
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL reset_release_ctl got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_load_use();
    // ld x5 in ALU1, add x6,x5,x1 in decode
    idle_inputs();
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd5; i_dec_rs2 = 5'd1;
    i_alu_load = 1'b1; i_alu_reg_write = 1'b1; i_alu_rd = 5'd5;
    #2;
    checks++;
    if (ctl !== C_LOADUSE) begin
      errors++;
      $display("FAIL load_use_bubble got %b want %b", ctl, C_LOADUSE);
    end
    tick();
    // bubble now in ALU1, add still in decode
    i_alu_load = 1'b0; i_alu_reg_write = 1'b0; i_alu_rd = 5'd0;
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL load_use_after got %b want %b", ctl, C_IDLE);
    end
    tick();
    // load to x0 with decode reading x0: no dependency
    i_alu_load = 1'b1; i_alu_reg_write = 1'b1; i_alu_rd = 5'd0;
    i_dec_rs1 = 5'd0; i_dec_rs2 = 5'd0;
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL load_use_x0 got %b want %b", ctl, C_IDLE);
    end
    tick();
    // match on rs2
    i_alu_rd = 5'd9; i_dec_rs1 = 5'd3; i_dec_rs2 = 5'd9;
    #2;
    checks++;
    if (ctl !== C_LOADUSE) begin
      errors++;
      $display("FAIL load_use_rs2 got %b want %b", ctl, C_LOADUSE);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_redirect();
    idle_inputs();
    i_alu_branch = 1'b1; i_alu_cond = 1'b1; i_alu_pc_target = 32'h100;
    i_alu_pc_next = 32'h44;
    // load-use on the same cycle must lose to the redirect
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd7;
    i_alu_load = 1'b1; i_alu_reg_write = 1'b1; i_alu_rd = 5'd7;
    #2;
    checks++;
    if (ctl !== C_REDIR) begin
      errors++;
      $display("FAIL redirect_ctl got %b want %b", ctl, C_REDIR);
    end
    checks++;
    if (o_pc_new !== 32'h100) begin
      errors++;
      $display("FAIL redirect_pc got %h want %h", o_pc_new, 32'h100);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL redirect_flush got %b want %b", ctl, C_FLUSH);
    end
    tick();
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL redirect_run got %b want %b", ctl, C_IDLE);
    end
    tick();
  endtask

  task automatic test_branch_pred();
    // predicted taken, actually not taken
    idle_inputs();
    i_alu_branch = 1'b1; i_alu_cond = 1'b0; i_alu_branch_pred = 1'b1;
    i_alu_pc_target = 32'h300; i_alu_pc_next = 32'h24;
    #2;
`ifdef RV_BRANCH_PRED_EN
    checks++;
    if (ctl !== C_REDIR || o_pc_new !== 32'h24) begin
      errors++;
      $display("FAIL pred_miss got %b/%h want %b/%h", ctl, o_pc_new, C_REDIR, 32'h24);
    end
    tick();
    idle_inputs();
    tick();
`else
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL static_not_taken got %b want %b", ctl, C_IDLE);
    end
    tick();
`endif
    // predicted taken and taken
    i_alu_branch = 1'b1; i_alu_cond = 1'b1; i_alu_branch_pred = 1'b1;
    i_alu_pc_target = 32'h300; i_alu_pc_next = 32'h24;
    #2;
`ifdef RV_BRANCH_PRED_EN
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL pred_hit got %b want %b", ctl, C_IDLE);
    end
    tick();
`else
    checks++;
    if (ctl !== C_REDIR || o_pc_new !== 32'h300) begin
      errors++;
      $display("FAIL static_taken got %b/%h want %b/%h", ctl, o_pc_new, C_REDIR, 32'h300);
    end
    tick();
    idle_inputs();
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_trap();
    idle_inputs();
    i_alu_to_trap = 1'b1; i_trap_vector = 32'h80;
    #2;
    checks++;
    if (o_pc_redirect !== 1'b0 || o_trap_take !== 1'b0) begin
      errors++;
      $display("FAIL trap_enter got %b%b want 00", o_pc_redirect, o_trap_take);
    end
    tick();
    i_alu_to_trap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_mem_busy = (i < 3);
      #2;
      checks++;
      if (ctl !== C_DRAIN) begin
        errors++;
        $display("FAIL trap_drain_%0d got %b want %b", i, ctl, C_DRAIN);
      end
      tick();
    end
    i_mem_busy = 1'b0;
    #2;
    checks++;
    if (ctl !== C_TRAPGO || o_pc_new !== 32'h80) begin
      errors++;
      $display("FAIL trap_go got %b/%h want %b/%h", ctl, o_pc_new, C_TRAPGO, 32'h80);
    end
    tick();
    #2;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL trap_flush got %b want %b", ctl, C_FLUSH);
    end
    tick();
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL trap_run got %b want %b", ctl, C_IDLE);
    end
    tick();
  endtask

  task automatic test_mem_busy_redirect();
    idle_inputs();
    i_alu_jump = 1'b1; i_alu_pc_target = 32'h200;
    i_mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (ctl !== C_MEMBUSY) begin
        errors++;
        $display("FAIL busy_hold_%0d got %b want %b", i, ctl, C_MEMBUSY);
      end
      tick();
    end
    i_mem_busy = 1'b0;
    #2;
    checks++;
    if (ctl !== C_REDIR || o_pc_new !== 32'h200) begin
      errors++;
      $display("FAIL busy_release got %b/%h want %b/%h", ctl, o_pc_new, C_REDIR, 32'h200);
    end
    tick();
    // bus goes busy again during FLUSH: fetch held, stay in FLUSH
    idle_inputs();
    i_mem_busy = 1'b1;
    #2;
    checks++;
    if (ctl !== C_FLUSH_BZ) begin
      errors++;
      $display("FAIL flush_busy got %b want %b", ctl, C_FLUSH_BZ);
    end
    tick();
    i_mem_busy = 1'b0;
    #2;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL flush_after_busy got %b want %b", ctl, C_FLUSH);
    end
    tick();
    #2;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL busy_run got %b want %b", ctl, C_IDLE);
    end
    tick();
  endtask

  task automatic test_reset_mid_trap();
    int pulses;
    idle_inputs();
    i_alu_to_trap = 1'b1; i_trap_vector = 32'h80;
    tick();
    i_alu_to_trap = 1'b0;
    i_mem_busy = 1'b1;
    #2;
    checks++;
    if (ctl !== C_DRAIN) begin
      errors++;
      $display("FAIL pre_reset_drain got %b want %b", ctl, C_DRAIN);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE || o_pc_new !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_drain got %b/%h want %b/%h", ctl, o_pc_new, C_IDLE, 32'h0);
    end
    i_mem_busy = 1'b0;
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      if (o_trap_take === 1'b1) pulses++;
      checks++;
      if (ctl !== C_IDLE) begin
        errors++;
        $display("FAIL post_reset_run_%0d got %b want %b", i, ctl, C_IDLE);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL post_reset_trap_pulse got %0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_branch_pred();
    test_trap();
    test_mem_busy_redirect();
    test_reset_mid_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
